// File: rtl/mult_stage_pkg.sv
// mult_stage_pkg -- PE configuration plus the control/data types shared by the PE pipeline stages.
// Revision 1.0
`default_nettype none

package PECfg;
    localparam int DWD     = 16;
    localparam int PSUMDWD = 32;
    localparam int PEROW   = 4;
endpackage

package PECtlCfg;
    import PECfg::*;

    localparam int SLICEW   = 4;
    localparam int MAXSLICE = DWD / SLICEW;
    localparam int SIDXW    = (MAXSLICE > 1) ? $clog2(MAXSLICE) : 1;
    localparam int SCNTW    = SIDXW + 1;
    localparam int NUMTW    = 4;

    typedef enum logic [1:0] {
        MODE_MAC  = 2'd0,
        MODE_XNOR = 2'd1,
        MODE_RSV2 = 2'd2,
        MODE_RSV3 = 2'd3
    } au_mode_e;

    typedef struct packed {
        au_mode_e         mode;
        logic [NUMTW-1:0] iNumT;
        logic [NUMTW-1:0] wNumT;
        logic [PEROW-1:0] AuMask;
    } AuCtl;

    typedef struct packed {
        logic [3:0] op;
        logic [3:0] shift;
    } SSctl;

    typedef struct packed {
        logic       valid;
        logic [6:0] addr;
    } PPctl;

    typedef struct packed {
        AuCtl msctl;
        SSctl ssctl;
        PPctl ssppctl;
    } FSpipeout;

    typedef struct packed {
        logic [DWD-1:0]     Input_FS;
        logic [DWD-1:0]     Weight_FS;
        logic [PSUMDWD-1:0] Psum_FS;
    } FSout;

    typedef struct packed {
        SSctl ssctl;
        PPctl ssppctl;
    } MSpipeout;

    typedef struct packed {
        logic [PSUMDWD-1:0] Psum_MS;
    } MSout;

    // A requested slice count of 0 means 1; anything above the operand width saturates.
    function automatic logic [SCNTW-1:0] clamp_slices(input logic [NUMTW-1:0] n);
        if (n == '0)
            return SCNTW'(1);
        else if (n > NUMTW'(MAXSLICE))
            return SCNTW'(MAXSLICE);
        else
            return SCNTW'(n);
    endfunction
endpackage

`default_nettype wire

// File: rtl/ms_slice_mac.sv
// ms_slice_mac -- per-row accumulator: XNOR-popcount update at load, or one nibble-product step per cycle.
// Revision 1.0
`default_nettype none

module ms_slice_mac
    import PECtlCfg::*;
#(
    parameter int DWD     = PECfg::DWD,
    parameter int PSUMDWD = PECfg::PSUMDWD
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               load,
    input  logic               step,
    input  logic               xnor_en,
    input  logic [DWD-1:0]     in_op,
    input  logic [DWD-1:0]     w_op,
    input  logic [PSUMDWD-1:0] psum_in,
    input  logic [SIDXW-1:0]   i_idx,
    input  logic [SIDXW-1:0]   j_idx,
    input  logic [SCNTW-1:0]   i_num,
    input  logic [SCNTW-1:0]   w_num,
    output logic [PSUMDWD-1:0] acc
);
    localparam int ONESW = $clog2(DWD + 1);

    logic [DWD-1:0]          a_q;
    logic [DWD-1:0]          b_q;
    logic [ONESW-1:0]        ones;
    logic [PSUMDWD-1:0]      xnor_sum;
    logic [SLICEW-1:0]       a_nib;
    logic [SLICEW-1:0]       b_nib;
    logic                    a_top;
    logic                    b_top;
    logic signed [SLICEW:0]  a_s;
    logic signed [SLICEW:0]  b_s;
    logic signed [2*SLICEW+1:0] prod;
    logic [PSUMDWD-1:0]      prod_ext;
    logic [SIDXW+2:0]        shamt;
    logic [PSUMDWD-1:0]      term;

    always_comb begin
        ones = '0;
        for (int k = 0; k < DWD; k++)
            ones = ones + {{(ONESW-1){1'b0}}, (in_op[k] ~^ w_op[k])};
    end

    // 2*popcount - DWD, folded straight into the incoming psum.
    assign xnor_sum = psum_in + PSUMDWD'({ones, 1'b0}) - PSUMDWD'(DWD);

    assign a_nib = a_q[{i_idx, 2'b00} +: SLICEW];
    assign b_nib = b_q[{j_idx, 2'b00} +: SLICEW];
    assign a_top = (SCNTW'(i_idx) == i_num - SCNTW'(1));
    assign b_top = (SCNTW'(j_idx) == w_num - SCNTW'(1));
    assign a_s   = {a_top & a_nib[SLICEW-1], a_nib};
    assign b_s   = {b_top & b_nib[SLICEW-1], b_nib};
    assign prod  = a_s * b_s;

    assign prod_ext = {{(PSUMDWD-2*SLICEW-2){prod[2*SLICEW+1]}}, prod};
    assign shamt    = {1'b0, i_idx, 2'b00} + {1'b0, j_idx, 2'b00};
    assign term     = prod_ext << shamt;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            a_q <= '0;
            b_q <= '0;
            acc <= '0;
        end else if (load) begin
            a_q <= in_op;
            b_q <= w_op;
            acc <= xnor_en ? xnor_sum : psum_in;
        end else if (step) begin
            acc <= acc + term;
        end
    end
endmodule

`default_nettype wire

// File: rtl/mult_stage.sv
// mult_stage -- PE multiply stage: rdy/ack handshake, slice sequencing and one accumulator per PE row.
// Revision 1.0
`default_nettype none

module mult_stage
    import PECtlCfg::*;
#(
    parameter int DWD     = PECfg::DWD,
    parameter int PSUMDWD = PECfg::PSUMDWD,
    parameter int PEROW   = PECfg::PEROW
) (
    input  logic     i_clk,
    input  logic     i_rstn,
    input  FSpipeout i_pipe,
    input  logic     i_FS_rdy,
    output logic     o_FS_ack,
    input  FSout     i_data [PEROW],
    output logic     o_MS_rdy,
    input  logic     i_MS_ack,
    output MSout     o_data [PEROW],
    output MSpipeout o_MSpipe_MS
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } ms_state_e;

    ms_state_e        state;
    logic [SIDXW-1:0] ci;
    logic [SIDXW-1:0] cj;
    logic [SCNTW-1:0] i_num;
    logic [SCNTW-1:0] w_num;
    logic             ms_rdy;
    MSpipeout         ms_pipe;
    logic             accept;
    logic             is_xnor;
    logic             step;
    logic             unused_mask;

    assign unused_mask = ^i_pipe.msctl.AuMask;

    // Combinational so a DONE beat can be acked and replaced in the same cycle.
    assign accept  = i_rstn && i_FS_rdy &&
                     ((state == ST_IDLE) || ((state == ST_DONE) && i_MS_ack));
    assign is_xnor = (i_pipe.msctl.mode == MODE_XNOR);
    assign step    = (state == ST_RUN);

    assign o_FS_ack    = accept;
    assign o_MS_rdy    = ms_rdy;
    assign o_MSpipe_MS = ms_pipe;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state   <= ST_IDLE;
            ci      <= '0;
            cj      <= '0;
            i_num   <= '0;
            w_num   <= '0;
            ms_rdy  <= 1'b0;
            ms_pipe <= '0;
        end else if (accept) begin
            ci      <= '0;
            cj      <= '0;
            i_num   <= clamp_slices(i_pipe.msctl.iNumT);
            w_num   <= clamp_slices(i_pipe.msctl.wNumT);
            ms_pipe <= '{ssctl: i_pipe.ssctl, ssppctl: i_pipe.ssppctl};
            state   <= is_xnor ? ST_DONE : ST_RUN;
            ms_rdy  <= is_xnor;
        end else begin
            case (state)
                ST_RUN: begin
                    // i is the fast index, j the slow one.
                    if (SCNTW'(ci) == i_num - SCNTW'(1)) begin
                        ci <= '0;
                        if (SCNTW'(cj) == w_num - SCNTW'(1)) begin
                            cj     <= '0;
                            state  <= ST_DONE;
                            ms_rdy <= 1'b1;
                        end else begin
                            cj <= cj + SIDXW'(1);
                        end
                    end else begin
                        ci <= ci + SIDXW'(1);
                    end
                end
                ST_DONE: begin
                    if (i_MS_ack) begin
                        state  <= ST_IDLE;
                        ms_rdy <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    for (genvar r = 0; r < PEROW; r++) begin : g_row
        logic [PSUMDWD-1:0] row_acc;

        ms_slice_mac #(
            .DWD     (DWD),
            .PSUMDWD (PSUMDWD)
        ) u_mac (
            .clk     (i_clk),
            .rstn    (i_rstn),
            .load    (accept),
            .step    (step),
            .xnor_en (is_xnor),
            .in_op   (i_data[r].Input_FS),
            .w_op    (i_data[r].Weight_FS),
            .psum_in (i_data[r].Psum_FS),
            .i_idx   (ci),
            .j_idx   (cj),
            .i_num   (i_num),
            .w_num   (w_num),
            .acc     (row_acc)
        );

        assign o_data[r].Psum_MS = row_acc;
    end
endmodule

`default_nettype wire

// File: tb/tb_mult_stage.sv
// tb_mult_stage -- directed stimulus with a per-cycle behavioural reference model for mult_stage.
// Revision 1.0
`default_nettype none

module tb_mult_stage;
    import PECfg::*;
    import PECtlCfg::*;

    logic     clk = 1'b0;
    logic     rstn;
    logic     fs_rdy;
    logic     fs_ack;
    logic     ms_rdy;
    logic     ms_ack;
    FSpipeout pipe;
    FSout     din  [PEROW];
    MSout     dout [PEROW];
    MSpipeout mspipe;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mult_stage dut (
        .i_clk       (clk),
        .i_rstn      (rstn),
        .i_pipe      (pipe),
        .i_FS_rdy    (fs_rdy),
        .o_FS_ack    (fs_ack),
        .i_data      (din),
        .o_MS_rdy    (ms_rdy),
        .i_MS_ack    (ms_ack),
        .o_data      (dout),
        .o_MSpipe_MS (mspipe)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int clampn(input logic [3:0] n);
        if (n == 0) return 1;
        if (n > 4) return 4;
        return int'(n);
    endfunction

    // Reference result straight from the arithmetic definition.
    function automatic logic [31:0] model_psum(input au_mode_e md, input logic [15:0] a,
                                               input logic [15:0] b, input logic [31:0] ps,
                                               input logic [3:0] itn, input logic [3:0] wtn);
        int     ones, in_n, wn_n;
        longint av, bv;
        if (md == MODE_XNOR) begin
            ones = $countones(~(a ^ b));
            return ps + 32'(2 * ones - 16);
        end
        in_n = clampn(itn);
        wn_n = clampn(wtn);
        av = longint'(a) & ((64'sd1 <<< (4 * in_n)) - 1);
        if (av >= (64'sd1 <<< (4 * in_n - 1))) av = av - (64'sd1 <<< (4 * in_n));
        bv = longint'(b) & ((64'sd1 <<< (4 * wn_n)) - 1);
        if (bv >= (64'sd1 <<< (4 * wn_n - 1))) bv = bv - (64'sd1 <<< (4 * wn_n));
        return ps + 32'(av * bv);
    endfunction

    // Reference model: pending result, cycles until it becomes visible, expected sideband.
    bit          m_known = 1'b0;
    bit          m_have  = 1'b0;
    bit          m_zero  = 1'b0;
    int          m_wait  = 0;
    logic [31:0] m_res [PEROW];
    logic [15:0] m_pipe = '0;

    always @(negedge clk) begin
        bit ea;
        bit er;
        er = m_have && (m_wait == 0);
        ea = rstn && fs_rdy && (!m_have || (er && ms_ack));
        if (m_known) begin
            chk("fs_ack", 32'(fs_ack), 32'(ea));
            chk("ms_rdy", 32'(ms_rdy), 32'(er));
            chk("ms_pipe", 32'(mspipe), 32'(m_pipe));
            if (m_zero || er)
                for (int r = 0; r < PEROW; r++)
                    chk("psum_row", dout[r].Psum_MS, m_zero ? 32'd0 : m_res[r]);
        end
        if (!rstn) begin
            m_known = 1'b1;
            m_have  = 1'b0;
            m_zero  = 1'b1;
            m_pipe  = '0;
        end else if (m_known) begin
            if (ea) begin
                for (int r = 0; r < PEROW; r++)
                    m_res[r] = model_psum(pipe.msctl.mode, din[r].Input_FS, din[r].Weight_FS,
                                          din[r].Psum_FS, pipe.msctl.iNumT, pipe.msctl.wNumT);
                m_have = 1'b1;
                m_zero = 1'b0;
                m_wait = (pipe.msctl.mode == MODE_XNOR) ? 0 :
                         clampn(pipe.msctl.iNumT) * clampn(pipe.msctl.wNumT);
                m_pipe = {pipe.ssctl, pipe.ssppctl};
            end else if (m_have && m_wait > 0) begin
                m_wait--;
            end else if (m_have && ms_ack) begin
                m_have = 1'b0;
            end
        end
    end

    task automatic drive_beat(input au_mode_e md, input logic [15:0] a, input logic [15:0] b,
                              input logic [31:0] ps, input logic [3:0] itn, input logic [3:0] wtn,
                              input logic [15:0] pp);
        fs_rdy            = 1'b1;
        pipe.msctl.mode   = md;
        pipe.msctl.iNumT  = itn;
        pipe.msctl.wNumT  = wtn;
        pipe.msctl.AuMask = 4'hA;
        {pipe.ssctl, pipe.ssppctl} = pp;
        for (int r = 0; r < PEROW; r++) begin
            din[r].Input_FS  = a + 16'(r * 3);
            din[r].Weight_FS = b - 16'(r);
            din[r].Psum_FS   = ps + 32'(r * 1000);
        end
    endtask

    task automatic wait_accept();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!fs_ack && n < 50);
        if (!fs_ack) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=no_ack required=ack");
        end
        @(posedge clk);
        #2 fs_rdy = 1'b0;
    endtask

    task automatic wait_rdy(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!ms_rdy && cyc < 100);
    endtask

    task automatic ack_once();
        @(posedge clk);
        #2 ms_ack = 1'b1;
        @(posedge clk);
        #2 ms_ack = 1'b0;
    endtask

    task automatic run_beat(input string name, input au_mode_e md, input logic [15:0] a,
                            input logic [15:0] b, input logic [31:0] ps, input logic [3:0] itn,
                            input logic [3:0] wtn, input logic [31:0] exp_psum, input int exp_cyc);
        int c;
        @(posedge clk);
        #2 drive_beat(md, a, b, ps, itn, wtn, 16'(checks * 37));
        wait_accept();
        wait_rdy(c);
        chk({name, "_latency"}, 32'(c), 32'(exp_cyc));
        chk({name, "_psum"}, dout[0].Psum_MS, exp_psum);
        ack_once();
    endtask

    initial begin
        int spurious;
        rstn   = 1'b0;
        fs_rdy = 1'b0;
        ms_ack = 1'b0;
        pipe   = '0;
        for (int r = 0; r < PEROW; r++) din[r] = '0;
        repeat (3) @(posedge clk);
        #2 rstn = 1'b1;
        @(negedge clk);
        chk("reset_rdy", 32'(ms_rdy), 32'd0);
        chk("reset_ack", 32'(fs_ack), 32'd0);
        chk("reset_psum", dout[0].Psum_MS, 32'd0);
        chk("reset_pipe", 32'(mspipe), 32'd0);

        run_beat("mac_full",  MODE_MAC,  16'hFFFD, 16'h0007, 32'd100, 4'd4, 4'd4, 32'd79, 17);
        run_beat("mac_red",   MODE_RSV2, 16'h0013, 16'h00F2, 32'd0,   4'd1, 4'd1, 32'd6, 2);
        run_beat("mac_zero",  MODE_MAC,  16'h0013, 16'h00F2, 32'd0,   4'd0, 4'd1, 32'd6, 2);
        run_beat("mac_clamp", MODE_MAC,  16'h0013, 16'h00F2, 32'd0,   4'd0, 4'd9, 32'd726, 5);
        run_beat("xnor_ones", MODE_XNOR, 16'hFFFF, 16'hFFFF, -32'sd5, 4'd0, 4'd0, 32'd11, 1);
        run_beat("xnor_zero", MODE_XNOR, 16'hFFFF, 16'h0000, 32'd0,   4'd2, 4'd3, 32'hFFFFFFF0, 1);
        run_beat("xnor_wrap", MODE_XNOR, 16'hFFFF, 16'hFFFF, 32'h7FFFFFFF, 4'd0, 4'd0, 32'h8000000F, 1);

        // Backpressure: A waits in DONE while B is offered.
        @(posedge clk);
        #2 drive_beat(MODE_XNOR, 16'h00FF, 16'h00F0, 32'd0, 4'd0, 4'd0, 16'h1111);
        wait_accept();
        drive_beat(MODE_XNOR, 16'h1234, 16'h1234, 32'd1, 4'd0, 4'd0, 16'h2222);
        repeat (5) begin
            @(negedge clk);
            chk("bp_fs_ack", 32'(fs_ack), 32'd0);
            chk("bp_rdy", 32'(ms_rdy), 32'd1);
            chk("bp_psum", dout[0].Psum_MS, 32'd8);
            chk("bp_pipe", 32'(mspipe), 32'h1111);
        end
        @(posedge clk);
        #2 ms_ack = 1'b1;
        @(negedge clk);
        chk("b2b_fs_ack", 32'(fs_ack), 32'd1);
        @(posedge clk);
        #2 ms_ack = 1'b0;
        drive_beat(MODE_MAC, 16'h0005, 16'hFFFE, 32'd10, 4'd1, 4'd1, 16'h3333);
        @(negedge clk);
        chk("b2b_rdy", 32'(ms_rdy), 32'd1);
        chk("b2b_psum", dout[0].Psum_MS, 32'd17);
        chk("b2b_pipe", 32'(mspipe), 32'h2222);
        @(posedge clk);
        #2 ms_ack = 1'b1;
        @(negedge clk);
        chk("b2b_mac_ack", 32'(fs_ack), 32'd1);
        @(posedge clk);
        #2 ms_ack = 1'b0;
        fs_rdy = 1'b0;
        @(negedge clk);
        chk("b2b_mac_run", 32'(ms_rdy), 32'd0);
        @(negedge clk);
        chk("b2b_mac_rdy", 32'(ms_rdy), 32'd1);
        chk("b2b_mac_psum", dout[0].Psum_MS, 32'd0);
        ack_once();

        // Reset during RUN cycle 3.
        @(posedge clk);
        #2 drive_beat(MODE_MAC, 16'hFFFD, 16'h0007, 32'd100, 4'd4, 4'd4, 16'h4444);
        wait_accept();
        repeat (2) @(posedge clk);
        #2 rstn = 1'b0;
        @(posedge clk);
        #2 rstn = 1'b1;
        @(negedge clk);
        chk("rst_run_rdy", 32'(ms_rdy), 32'd0);
        chk("rst_run_pipe", 32'(mspipe), 32'd0);
        for (int r = 0; r < PEROW; r++) chk("rst_run_psum", dout[r].Psum_MS, 32'd0);
        spurious = 0;
        repeat (20) begin
            @(negedge clk);
            if (ms_rdy) spurious++;
        end
        chk("rst_run_no_result", 32'(spurious), 32'd0);
        run_beat("after_rst", MODE_MAC, 16'h8000, 16'h0002, 32'd0, 4'd4, 4'd1, 32'hFFFF0000, 5);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end
endmodule

`default_nettype wire

// File: doc/mult_stage.md
# mult_stage

Multiply stage (MS) of the PE pipeline, directly downstream of the fetch stage. Consumes fetched input/weight/psum triples for all PE rows plus the forwarded `MSctl`. Computes either a binary XNOR-popcount dot step or a nibble-serial signed multiply-accumulate per row. Hands the updated psums and the forwarded sum-stage control to the sum stage (SS) over a rdy/ack handshake.

## Interface
- `DWD`, default `PECfg::DWD` (16): operand width; must be a multiple of 4.
- `PSUMDWD`, default `PECfg::PSUMDWD` (32): psum width, at least 2·`DWD`.
- `PEROW`, default `PECfg::PEROW` (4): number of PE rows, processed in lockstep.
- `i_clk`  in  1: clock; everything is rising-edge.
- `i_rstn`  in  1: reset, synchronous, active-low.
- `i_pipe`  in  `FSpipeout`: `msctl` (`AuCtl`: `mode`, `iNumT`, `wNumT`, `AuMask`), `ssctl`, `ssppctl`.
- `i_FS_rdy`  in  1: fetch stage holds a valid beat.
- `o_FS_ack`  out  1: MS accepts the beat this cycle.
- `i_data[PEROW]`  in  `FSout`: `Input_FS`, `Weight_FS`, `Psum_FS`.
- `o_MS_rdy`  out  1: result valid.
- `i_MS_ack`  in  1: sum stage consumes the result.
- `o_data[PEROW]`  out  `MSout`: `Psum_MS[PSUMDWD]`.
- `o_MSpipe_MS`  out  `MSpipeout`: `{ssctl, ssppctl}`, registered at accept.

## Operation
- Transfer on either side occurs only when rdy && ack are high in the same cycle.
- `o_FS_ack = i_FS_rdy && (state==IDLE || (state==DONE && i_MS_ack))`. This is combinational, so back-to-back beats are possible.
- On accept, the block latches operands, psum, `mode`, the clamped slice counts and `o_MSpipe_MS`.
- Slice counts: `iN = clamp(iNumT, 1, DWD/4)`, `wN = clamp(wNumT, 1, DWD/4)`. A value of 0 is treated as 1.
- `AuMask` is ignored by this block.
- XNOR mode (`mode==XNOR`):
  - `p = 2·popcount(~(in ^ w)) − DWD`, computed over all `DWD` bits.
  - `Psum_MS = Psum_FS + sext(p)`, computed at the accept edge.
- Any other mode is nibble-serial MAC:
  - Slice `a_i = in[4i+3:4i]`; it is signed if `i==iN−1`, otherwise zero-extended. Weight slice `b_j` follows the same rule with `wN`.
  - Each RUN cycle adds `sext(a_i·b_j) << 4(i+j)` to the accumulator.
  - Iteration order: `i` is the fast index, `j` the slow index.
  - The accumulator is initialised to `Psum_FS`.
  - Final value: `Psum_FS + sext(in[4iN−1:0])·sext(w[4wN−1:0])`, modulo 2^`PSUMDWD` (wrap, no saturation).
- State machine:
  - IDLE: on accept, go to DONE if XNOR, else go to RUN.
  - RUN: a counter counts `iN·wN` cycles, then the state goes to DONE.
  - DONE: `o_MS_rdy=1`. On ack, accept a new beat if one is offered (go to RUN or DONE), else go to IDLE.
- `o_data` and `o_MSpipe_MS` are held stable while `o_MS_rdy` is high and unacked.

## Timing
- Reset (`i_rstn` low at an edge): state IDLE, counters 0, and all outputs 0: `o_FS_ack`, `o_MS_rdy`, `o_data`, `o_MSpipe_MS`.
- Reset mid-RUN or mid-DONE abandons the beat; no result is emitted.
- Latency, with accept at edge 0:
  - XNOR: `o_MS_rdy` is high in cycle 1.
  - MAC: `o_MS_rdy` is high in cycle `iN·wN + 1`.
- `i_FS_rdy` during RUN, or during DONE without ack, leaves `o_FS_ack` low.
- Ack and new accept in the same DONE cycle: the new beat's results replace the outputs. For XNOR, `o_MS_rdy` stays high the following cycle with the new data.
- `i_MS_ack` while `o_MS_rdy` is low has no effect.

## Structure
- Add `MSpipeout {SSctl ssctl; PPctl ssppctl;}` and `MSout {logic [PSUMDWD-1:0] Psum_MS;}` to package `PECtlCfg`.
- Add the constants `SLICEW=4` and `MAXSLICE=DWD/SLICEW` to the same package.
- The FSM, slice counters and handshake live once in `mult_stage`.
- One sub-module, `ms_slice_mac`, is instantiated `PEROW` times. It takes the slice indices and a load/step/xnor control and holds the row's accumulator.

## Test plan
- MAC full precision: `in=16'hFFFD` (−3), `w=16'h0007`, `iN=wN=4`, `psum=100` → `Psum_MS=79`, `o_MS_rdy` first high in cycle 17.
- MAC reduced precision: `in=16'h0013`, `w=16'h00F2`, `iN=wN=1`, `psum=0` → `Psum_MS=6` in cycle 2. Also `iNumT=0` gives the same result.
- XNOR: `in=w=16'hFFFF`, `psum=−5` → 11. Then `in=16'hFFFF`, `w=0`, `psum=0` → −16 (`32'hFFFFFFF0`). Both in cycle 1.
- Backpressure and back-to-back: hold `i_MS_ack` low for 5 cycles with `i_FS_rdy` high. `o_FS_ack` stays low and outputs stay stable. On the ack cycle, `o_FS_ack=1` and the next result follows without an IDLE cycle.
- Wrap: `psum=32'h7FFFFFFF`, XNOR `in=w=16'hFFFF` → `32'h8000000F`.
- Reset at RUN cycle 3 → outputs 0 next cycle, no `o_MS_rdy`. A fresh beat is then processed correctly.
